// File: rtl/cvw_pkg.sv
// Shared cvw declarations used by the RVVI transmit arbiter: FSM state
// encoding and the default frame-length limit.
package cvw_pkg;

  localparam int DEFAULT_MAX_FRAME_WORDS = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } statetype;

endpackage

// File: rtl/rvvi_tx_arbiter_counter.sv
// Free-running up-counter with synchronous clear. It serves as both the
// beat counter and the inter-frame gap counter of the arbiter.
module rvvi_tx_arbiter_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (en)        count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/rvvi_tx_arbiter.sv
// Two-source, frame-granular round-robin arbiter onto the MAC write channel.
// Defining RVVI_TX_ARB_STATS_EN adds per-source completed-frame counters.
module rvvi_tx_arbiter import cvw_pkg::*; #(
  parameter int MAX_FRAME_WORDS   = DEFAULT_MAX_FRAME_WORDS,
  parameter int FRAME_COUNT_WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  S0Wdata,
  input  logic [3:0]                   S0Wstrb,
  input  logic                         S0Wlast,
  input  logic                         S0Wvalid,
  output logic                         S0Wready,
  input  logic [31:0]                  S1Wdata,
  input  logic [3:0]                   S1Wstrb,
  input  logic                         S1Wlast,
  input  logic                         S1Wvalid,
  output logic                         S1Wready,
  output logic [31:0]                  MWdata,
  output logic [3:0]                   MWstrb,
  output logic                         MWlast,
  output logic                         MWvalid,
  input  logic                         MWready,
  input  logic [31:0]                  InterFrameGap,
  output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
  output logic                         Overrun,
`ifdef RVVI_TX_ARB_STATS_EN
  output logic [31:0]                  S0Frames,
  output logic [31:0]                  S1Frames,
`endif
  output statetype                     DebugState
);

  // Handshake: a beat moves when MWvalid && MWready on a rising edge; the
  // granted source sees SnWready == MWready, every other ready is held low.

  localparam int BEAT_W = $clog2(MAX_FRAME_WORDS) + 1;

  statetype          State, NextState;
  logic              LastGrant;
  logic              BeatAccept, LastDone, GapDone;
  logic              InGrant, BeatClear, GapClear, GapEn;
  logic [BEAT_W-1:0] BeatCount;
  logic [31:0]       GapCount;

  assign DebugState = State;

  always_ff @(posedge clk) begin
    if (reset) State <= IDLE;
    else       State <= NextState;
  end

  // Channel steering: the granted source drives the MAC combinationally.
  always_comb begin
    MWdata   = '0;
    MWstrb   = '0;
    MWlast   = 1'b0;
    MWvalid  = 1'b0;
    S0Wready = 1'b0;
    S1Wready = 1'b0;
    case (State)
      GRANT0: begin
        MWdata   = S0Wdata;
        MWstrb   = S0Wstrb;
        MWlast   = S0Wlast;
        MWvalid  = S0Wvalid;
        S0Wready = MWready;
      end
      GRANT1: begin
        MWdata   = S1Wdata;
        MWstrb   = S1Wstrb;
        MWlast   = S1Wlast;
        MWvalid  = S1Wvalid;
        S1Wready = MWready;
      end
      default: ;
    endcase
  end

  assign InGrant    = (State == GRANT0) || (State == GRANT1);
  assign BeatAccept = MWvalid & MWready;
  assign LastDone   = BeatAccept & MWlast;
  // Live compare against the current gap setting; >= also releases the gap
  // promptly if the setting shrinks below the cycles already spent.
  assign GapDone    = ({1'b0, GapCount} + 33'd1) >= {1'b0, InterFrameGap};

  always_comb begin
    NextState = State;
    case (State)
      IDLE: begin
        if (S0Wvalid && S1Wvalid) NextState = LastGrant ? GRANT0 : GRANT1;
        else if (S0Wvalid)        NextState = GRANT0;
        else if (S1Wvalid)        NextState = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (LastDone) NextState = (InterFrameGap == 32'd0) ? IDLE : GAP;
      end
      GAP: begin
        if (GapDone) NextState = IDLE;
      end
      default: NextState = IDLE;
    endcase
  end

  assign BeatClear = ~InGrant;
  assign GapClear  = (State != GAP);
  assign GapEn     = (State == GAP);

  rvvi_tx_arbiter_counter #(.WIDTH(BEAT_W)) beatCounter (
    .clk   (clk),
    .reset (reset),
    .clear (BeatClear),
    .en    (BeatAccept),
    .count (BeatCount)
  );

  rvvi_tx_arbiter_counter #(.WIDTH(32)) gapCounter (
    .clk   (clk),
    .reset (reset),
    .clear (GapClear),
    .en    (GapEn),
    .count (GapCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      LastGrant  <= 1'b1;
      FrameCount <= '0;
      Overrun    <= 1'b0;
    end else begin
      if (LastDone) begin
        LastGrant  <= (State == GRANT1);
        FrameCount <= FrameCount + FRAME_COUNT_WIDTH'(1);
      end
      // Overlong frames are flagged but still run to their last beat.
      if (BeatAccept && !MWlast && (BeatCount == BEAT_W'(MAX_FRAME_WORDS - 1)))
        Overrun <= 1'b1;
    end
  end

`ifdef RVVI_TX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      S0Frames <= '0;
      S1Frames <= '0;
    end else if (LastDone) begin
      if (State == GRANT0) S0Frames <= S0Frames + 32'd1;
      if (State == GRANT1) S1Frames <= S1Frames + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_tx_arbiter.sv
// Scoreboard bench for rvvi_tx_arbiter: a frame-level round-robin model
// predicts the MAC beat stream, a negedge monitor checks it.
module tb_rvvi_tx_arbiter;
  import cvw_pkg::*;

  localparam int W    = 37;  // {data[31:0], strb[3:0], last}
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] S0Wdata, S1Wdata, MWdata, InterFrameGap;
  logic [3:0]  S0Wstrb, S1Wstrb, MWstrb;
  logic        S0Wlast, S1Wlast, MWlast;
  logic        S0Wvalid, S1Wvalid, MWvalid;
  logic        S0Wready, S1Wready, MWready;
  logic [63:0] FrameCount;
  logic        Overrun;
  statetype    DebugState;
`ifdef RVVI_TX_ARB_STATS_EN
  logic [31:0] S0Frames, S1Frames;
`endif

  rvvi_tx_arbiter #(.MAX_FRAME_WORDS(MAXW), .FRAME_COUNT_WIDTH(64)) dut (
    .clk(clk), .reset(reset),
    .S0Wdata(S0Wdata), .S0Wstrb(S0Wstrb), .S0Wlast(S0Wlast),
    .S0Wvalid(S0Wvalid), .S0Wready(S0Wready),
    .S1Wdata(S1Wdata), .S1Wstrb(S1Wstrb), .S1Wlast(S1Wlast),
    .S1Wvalid(S1Wvalid), .S1Wready(S1Wready),
    .MWdata(MWdata), .MWstrb(MWstrb), .MWlast(MWlast),
    .MWvalid(MWvalid), .MWready(MWready),
    .InterFrameGap(InterFrameGap), .FrameCount(FrameCount), .Overrun(Overrun),
`ifdef RVVI_TX_ARB_STATS_EN
    .S0Frames(S0Frames), .S1Frames(S1Frames),
`endif
    .DebugState(DebugState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] s0_src[$], s1_src[$];
  logic [W-1:0] m0[$], m1[$];
  logic         model_last;
  int           exp_frames, exp_s0f, exp_s1f;
  int           ready_mode;
  int           bubble_max;
  logic         drv_timeout;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MAC back-pressure: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    MWready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       MWready = 1'b1;
        1:       MWready = ~MWready;
        default: MWready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    S0Wvalid = 1'b0; S1Wvalid = 1'b0;
    s0_src.delete(); s1_src.delete(); m0.delete(); m1.delete(); exp_q.delete();
    model_last = 1'b1;
    exp_frames = 0; exp_s0f = 0; exp_s1f = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic gen_frame(input int src, input int len);
    logic [W-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = {$urandom, 4'($urandom_range(0, 15)), (i == len - 1)};
      if (src == 0) begin s0_src.push_back(b); m0.push_back(b); end
      else          begin s1_src.push_back(b); m1.push_back(b); end
    end
  endtask

  task automatic set_src(input int src, input logic [W-1:0] b, input logic v);
    if (src == 0) begin {S0Wdata, S0Wstrb, S0Wlast} = b; S0Wvalid = v; end
    else          begin {S1Wdata, S1Wstrb, S1Wlast} = b; S1Wvalid = v; end
  endtask

  task automatic drive_src(input int src, input int delay);
    logic [W-1:0] b;
    logic [W-1:0] junk;
    logic         hs;
    int           guard;
    repeat (delay) begin @(posedge clk); #1; end
    while (((src == 0) ? s0_src.size() : s1_src.size()) > 0 && !drv_timeout) begin
      if (src == 0) b = s0_src.pop_front();
      else          b = s1_src.pop_front();
      set_src(src, b, 1'b1);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 300) begin
        @(negedge clk);
        hs = (src == 0) ? S0Wready : S1Wready;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) begin
        $display("FAIL src%0d_handshake_timeout: got no ready expected ready within 300 cycles", src);
        drv_timeout = 1'b1;
      end
      junk = {$urandom, 4'h0, 1'b0};
      set_src(src, junk, 1'b0);
      // Mid-frame valid withdrawal; frames themselves are presented back to back.
      if (!b[0]) repeat ($urandom_range(0, bubble_max)) begin @(posedge clk); #1; end
    end
  endtask

  // Reference: whole frames alternate when both sources have work; the
  // source not served last wins, and source 0 wins first after reset.
  task automatic predict();
    int           pick;
    logic [W-1:0] b;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) pick = model_last ? 0 : 1;
      else                                pick = (m0.size() > 0) ? 0 : 1;
      do begin
        if (pick == 0) b = m0.pop_front();
        else           b = m1.pop_front();
        exp_q.push_back(b);
      end while (!b[0]);
      model_last = (pick == 1);
      exp_frames++;
      if (pick == 0) exp_s0f++; else exp_s1f++;
    end
  endtask

  task automatic run_phase(input int n0, input int n1, input int len, input int ifg,
                           input int rmode, input int bub, input int s1_delay);
    int waited;
    @(posedge clk); #1;
    InterFrameGap = 32'(ifg);
    ready_mode    = rmode;
    bubble_max    = bub;
    drv_timeout   = 1'b0;
    for (int f = 0; f < n0; f++) gen_frame(0, (len == 0) ? $urandom_range(1, MAXW) : len);
    for (int f = 0; f < n1; f++) gen_frame(1, (len == 0) ? $urandom_range(1, MAXW) : len);
    predict();
    fork
      drive_src(0, 0);
      drive_src(1, s1_delay);
    join
    chk("driver_timeout", 64'(drv_timeout), 64'd0);
    waited = 0;
    while ((exp_q.size() > 0 || DebugState != IDLE) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_timeout", 64'(waited >= 500), 64'd0);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("frame_count", FrameCount, 64'(exp_frames));
`ifdef RVVI_TX_ARB_STATS_EN
    chk("s0_frames", 64'(S0Frames), 64'(exp_s0f));
    chk("s1_frames", 64'(S1Frames), 64'(exp_s1f));
`endif
  endtask

  // ---------------- scoreboard monitor ----------------
  int           gap_run   = 0;
  int           beat_idx  = 0;
  logic         last_seen = 1'b0;
  logic         exp_ovr   = 1'b0;
  logic [W-1:0] got, e;

  always @(negedge clk) begin
    if (reset) begin
      gap_run = 0; beat_idx = 0; last_seen = 1'b0; exp_ovr = 1'b0;
    end else begin
      if (last_seen) begin
        chk("state_after_last", 64'(DebugState), 64'((InterFrameGap == 0) ? IDLE : GAP));
        last_seen = 1'b0;
      end
      if (DebugState == GAP) gap_run++;
      else if (gap_run > 0) begin
        chk("gap_cycles", 64'(gap_run), 64'(InterFrameGap));
        gap_run = 0;
      end
      if (DebugState == IDLE || DebugState == GAP)
        chk("quiet_outputs", {61'd0, MWvalid, S0Wready, S1Wready}, 64'd0);
      if (DebugState == GRANT0)
        chk("grant0_mirror", {61'd0, S1Wready, S0Wready, MWvalid}, {61'd0, 1'b0, MWready, S0Wvalid});
      if (DebugState == GRANT1)
        chk("grant1_mirror", {61'd0, S0Wready, S1Wready, MWvalid}, {61'd0, 1'b0, MWready, S1Wvalid});
      if (MWvalid && MWready) begin
        got = {MWdata, MWstrb, MWlast};
        if (exp_q.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("beat_order", 64'(got), 64'(e));
        end
        chk("overrun", 64'(Overrun), 64'(exp_ovr));
        beat_idx++;
        if (MWlast) begin
          last_seen = 1'b1;
          beat_idx  = 0;
        end else if (beat_idx == MAXW) exp_ovr = 1'b1;
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b1;
    S0Wdata = '0; S0Wstrb = '0; S0Wlast = 1'b0; S0Wvalid = 1'b0;
    S1Wdata = '0; S1Wstrb = '0; S1Wlast = 1'b0; S1Wvalid = 1'b0;
    InterFrameGap = '0; ready_mode = 0; bubble_max = 0; drv_timeout = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_state", 64'(DebugState), 64'(IDLE));
    chk("rst_frame_count", FrameCount, 64'd0);
    chk("rst_overrun", 64'(Overrun), 64'd0);
    chk("rst_outputs", {61'd0, MWvalid, S0Wready, S1Wready}, 64'd0);

    run_phase(1, 0, 3, 2, 0, 0, 0);  // single 3-beat frame, gap of 2
    do_reset();
    run_phase(2, 1, 3, 1, 0, 0, 0);  // contention: S0, S1, S0
    do_reset();
    run_phase(1, 1, 4, 0, 0, 0, 2);  // S1 arrives mid S0 frame
    do_reset();
    run_phase(1, 0, 4, 0, 1, 0, 0);  // MWready toggling
    do_reset();
    run_phase(3, 0, 2, 0, 0, 0, 0);  // back to back, no gap
    do_reset();
    run_phase(1, 0, 6, 1, 0, 0, 0);  // overlong frame
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 64'(Overrun), 64'd1);
    do_reset();
    @(negedge clk);
    chk("overrun_cleared", 64'(Overrun), 64'd0);

    for (int r = 0; r < 12; r++)
      run_phase($urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rvvi_tx_arbiter.md
RVVI_TX_ARBITER -- requirements
Module: rvvi_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_FRAME_WORDS, default 512: beats per frame before the overrun flag sets.
REQ-002 The block SHALL have parameter FRAME_COUNT_WIDTH, default 64: width of FrameCount.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 S0Wdata/S1Wdata  input  32  write data from source 0 (RVVI packetizer) and source 1 (control/ack frame source).
REQ-006 S0Wstrb/S1Wstrb  input  4  byte strobes per source.
REQ-007 S0Wlast/S1Wlast  input  1  last beat of a frame per source.
REQ-008 S0Wvalid/S1Wvalid  input  1  beat valid per source.
REQ-009 S0Wready/S1Wready  output  1  beat accepted per source.
REQ-010 MWdata  output  32, MWstrb  output  4, MWlast  output  1, MWvalid  output  1: write data channel to the MAC.
REQ-011 MWready  input  1  MAC accepts beat.
REQ-012 InterFrameGap  input  32  minimum idle cycles between frames on the MAC side.
REQ-013 FrameCount  output  FRAME_COUNT_WIDTH  completed frames, all sources.
REQ-014 Overrun  output  1  sticky: a frame exceeded MAX_FRAME_WORDS.

Function
REQ-015 The FSM SHALL have states IDLE, GRANT0, GRANT1 and GAP.
REQ-016 IDLE: S0Wvalid only -> GRANT0; S1Wvalid only -> GRANT1; both -> the source not granted last (LastGrant); neither -> IDLE.
REQ-017 Arbitration SHALL be frame-granular: the grant is held from the first beat through the beat with Wlast=1, MWvalid=1 and MWready=1.
REQ-018 In GRANTn, MWdata/MWstrb/MWlast/MWvalid SHALL equal source n's signals combinationally, and SnWready SHALL equal MWready.
REQ-019 The non-granted SnWready SHALL be 0. In IDLE and GAP, MWvalid and both SnWready SHALL be 0.
REQ-020 On the last-beat handshake: LastGrant <= n; FrameCount increments by 1 (wraps modulo 2^FRAME_COUNT_WIDTH); next state is IDLE if InterFrameGap==0, else GAP.
REQ-021 GAP: a 32-bit gap counter cleared on entry increments each cycle; exit to IDLE in the cycle the count equals InterFrameGap-1, giving exactly InterFrameGap GAP cycles.
REQ-022 A beat counter SHALL clear on entry to GRANTn and increment per accepted beat; if it reaches MAX_FRAME_WORDS without a last beat, Overrun SHALL set and stay set until reset. The grant is not released.
REQ-023 Valid withdrawn mid-frame by the granted source SHALL hold the grant, with MWvalid=0 that cycle.
REQ-024 A change of InterFrameGap during GAP SHALL take effect in the same cycle, as a live comparison.

Reset
REQ-025 On reset: state IDLE, LastGrant=1 (source 0 wins the first contention), FrameCount=0, Overrun=0, beat and gap counters 0, MWvalid=0, S0Wready=S1Wready=0.
REQ-026 Reset mid-frame SHALL abandon the frame immediately, with no partial-frame count.

Configuration
REQ-027 Macro RVVI_TX_ARB_STATS_EN defined: adds outputs S0Frames and S1Frames (32 bits each, reset 0, wrapping), counting completed frames per source on the REQ-020 event.
REQ-028 Macro RVVI_TX_ARB_STATS_EN undefined: those ports and counters are absent, and all other behaviour is identical.

Structure
REQ-029 The state enum and the default MAX_FRAME_WORDS constant SHALL live in the shared cvw package.
REQ-030 The gap and beat counters SHALL reuse the existing counter sub-module; the arbitration decision SHALL be inline, with no arbiter sub-module.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Reset, then S0 sends a 3-beat frame with MWready=1 and InterFrameGap=2: 3 MAC beats, then MWlast, FrameCount=1, exactly 2 GAP cycles.
- S0 and S1 valid together from reset: S0 frame first, then S1; a third contention goes to S0; FrameCount=3.
- S1 raises valid mid-S0 frame: S1Wready stays 0 until the S0 last beat, and no S1 beat is interleaved.
- MWready toggles 1,0,1,0 during a 4-beat frame: data is preserved in order, and SnWready mirrors MWready.
- MAX_FRAME_WORDS=4 and a 6-beat frame: Overrun rises on the 4th beat, the frame completes, and Overrun stays 1 until reset.
- InterFrameGap=0, back-to-back S0 frames: IDLE follows the last beat directly, with no GAP state.
